// File: rtl/pwm_seq_ctrl.sv
// Four-channel PWM sequencer: shadow registers written over valid/ready are
// committed to the live PWM state only at period boundaries, with optional duty ramping.
module pwm_seq_ctrl #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int PW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [2:0]     wr_addr,
    input  logic [7:0]     wr_data,
    output logic [NCH-1:0] pwm_out,
    output logic           period_tick,
    output logic           busy
);

    localparam logic [DW-1:0] CNT_LAST = {{(DW-1){1'b1}}, 1'b0};

    logic [DW-1:0]  target [NCH];
    logic [DW-1:0]  active [NCH];
    logic [PW-1:0]  prescale_sh;
    logic [PW-1:0]  prescale_act;
    logic [DW-1:0]  step;
    logic [NCH-1:0] mask_sh;
    logic [NCH-1:0] mask_act;
    logic [PW-1:0]  pre_cnt;
    logic [DW-1:0]  cnt;

    logic           tick;
    logic           boundary;
    logic           wr_fire;
    logic [NCH-1:0] pwm_p0;

    // Move cur toward tgt by at most stp; the difference is taken one bit wider
    // so the magnitude never wraps and the result cannot overshoot.
    function automatic logic [DW-1:0] ramp_toward(
        input logic [DW-1:0] cur,
        input logic [DW-1:0] tgt,
        input logic [DW-1:0] stp
    );
        logic signed [DW:0] diff;
        logic        [DW:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
        if (stp == '0 || mag <= {1'b0, stp}) begin
            ramp_toward = tgt;
        end else if (diff[DW]) begin
            ramp_toward = cur - stp;
        end else begin
            ramp_toward = cur + stp;
        end
    endfunction

    assign tick     = (pre_cnt == prescale_act);
    assign boundary = ena && tick && (cnt == CNT_LAST);
    assign wr_ready = ena && !boundary;
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            busy = busy | (active[i] != target[i]);
        end
    end

    always_comb begin
        pwm_p0 = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_p0[i] = ena && mask_act[i] && (cnt < active[i]);
        end
    end

    // Shadow register writes; boundary and an accepted write never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                target[i] <= '0;
            end
            prescale_sh <= '0;
            step        <= '0;
            mask_sh     <= '0;
        end else if (wr_fire) begin
            if (!wr_addr[2]) begin
                target[wr_addr[1:0]] <= wr_data[DW-1:0];
            end else begin
                case (wr_addr[1:0])
                    2'd0:    prescale_sh <= wr_data[PW-1:0];
                    2'd1:    step        <= wr_data[DW-1:0];
                    2'd2:    mask_sh     <= wr_data[NCH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Timebase: everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (ena) begin
            if (tick) begin
                pre_cnt <= '0;
                cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Commit stage: live state changes only on the same edge as the counter wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                active[i] <= '0;
            end
            prescale_act <= '0;
            mask_act     <= '0;
        end else if (boundary) begin
            for (int i = 0; i < NCH; i++) begin
                active[i] <= ramp_toward(active[i], target[i], step);
            end
            prescale_act <= prescale_sh;
            mask_act     <= mask_sh;
        end
    end

    // Output stage: one clock behind the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= pwm_p0;
            period_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Randomized/scenario bench for pwm_seq_ctrl against a period-level integer model.
module tb_pwm_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic [3:0] pwm_out;
    logic       period_tick;
    logic       busy;

    pwm_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .pwm_out(pwm_out), .period_tick(period_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, plain integers.
    int m_tgt [4];
    int m_act [4];
    int m_ps_sh, m_ps_act, m_step, m_pre, m_cnt;
    bit [3:0] m_mask_sh, m_mask_act, m_pwm;
    bit m_ptick;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_tgt[i] = 0;
            m_act[i] = 0;
        end
        m_ps_sh = 0; m_ps_act = 0; m_step = 0; m_pre = 0; m_cnt = 0;
        m_mask_sh = '0; m_mask_act = '0; m_pwm = '0; m_ptick = 1'b0;
    endtask

    function automatic bit m_busy();
        bit b = 1'b0;
        for (int i = 0; i < 4; i++) if (m_tgt[i] != m_act[i]) b = 1'b1;
        return b;
    endfunction

    function automatic bit m_at_boundary();
        return (ena === 1'b1) && (m_pre == m_ps_act) && (m_cnt == 254);
    endfunction

    // Advance one clock: model and DUT side by side, then compare all outputs.
    task automatic cycle();
        bit bnd, rdy, tk;
        bit [3:0] np;
        int d, mv;
        tk  = (m_pre == m_ps_act);
        bnd = m_at_boundary();
        rdy = (ena === 1'b1) && !bnd;
        for (int i = 0; i < 4; i++)
            np[i] = (ena === 1'b1) && m_mask_act[i] && (m_cnt < m_act[i]);
        @(posedge clk);
        #1;
        m_pwm = np;
        m_ptick = bnd;
        if (wr_valid === 1'b1 && rdy) begin
            case (wr_addr)
                3'd0, 3'd1, 3'd2, 3'd3: m_tgt[wr_addr] = int'(wr_data);
                3'd4: m_ps_sh = int'(wr_data);
                3'd5: m_step = int'(wr_data);
                3'd6: m_mask_sh = wr_data[3:0];
                default: ;
            endcase
        end
        if (ena === 1'b1) begin
            if (tk) begin
                m_pre = 0;
                m_cnt = (m_cnt + 1) % 255;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        if (bnd) begin
            m_ps_act = m_ps_sh;
            m_mask_act = m_mask_sh;
            for (int i = 0; i < 4; i++) begin
                d = m_tgt[i] - m_act[i];
                mv = (d < 0) ? -d : d;
                if (m_step != 0 && mv > m_step) mv = m_step;
                m_act[i] = (d < 0) ? m_act[i] - mv : m_act[i] + mv;
            end
        end
        n_cmp++;
        if (pwm_out !== m_pwm) begin
            n_bad++;
            if (n_bad < 30) $display("FAIL cyc_pwm_out: got %b want %b at %0t", pwm_out, m_pwm, $time);
        end
        n_cmp++;
        if (period_tick !== m_ptick) begin
            n_bad++;
            if (n_bad < 30) $display("FAIL cyc_period_tick: got %b want %b at %0t", period_tick, m_ptick, $time);
        end
        n_cmp++;
        if (busy !== m_busy()) begin
            n_bad++;
            if (n_bad < 30) $display("FAIL cyc_busy: got %b want %b at %0t", busy, m_busy(), $time);
        end
        n_cmp++;
        if (wr_ready !== ((ena === 1'b1) && !m_at_boundary())) begin
            n_bad++;
            if (n_bad < 30) $display("FAIL cyc_wr_ready: got %b at %0t", wr_ready, $time);
        end
    endtask

    task automatic reset_dut();
        wr_valid = 1'b0;
        ena = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        bit done = 1'b0;
        wr_valid = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int k = 0; k < 4 && !done; k++) begin
            done = (wr_ready === 1'b1);
            cycle();
        end
        wr_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL write_accept: addr %0d never accepted, required accept", a);
        end
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            cycle();
            if (period_tick === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL wait_tick: no period_tick in 2000 clocks, required one");
        end
    endtask

    task automatic run_count(input int n, input int ch, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            if (pwm_out[ch] === 1'b1) highs++;
            if (period_tick === 1'b1) ticks++;
        end
    endtask

    task automatic test_reset();
        ena = 1'b1;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (pwm_out !== 4'b0 || period_tick !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got pwm=%b tick=%b busy=%b want 0/0/0", pwm_out, period_tick, busy);
        end
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
        reset_dut();
        repeat (10) cycle();
    endtask

    task automatic test_basic();
        int h, t;
        reset_dut();
        do_write(3'd6, 8'h01);
        do_write(3'd0, 8'd64);
        do_write(3'd5, 8'd0);
        wait_tick();
        for (int p = 0; p < 2; p++) begin
            run_count(255, 0, h, t);
            n_cmp++;
            if (h != 64 || t != 1 || period_tick !== 1'b1) begin
                n_bad++;
                $display("FAIL basic_period: high=%0d ticks=%0d want 64/1", h, t);
            end
        end
    endtask

    task automatic test_ramp();
        int h, t;
        int duty [7] = '{16, 32, 48, 64, 80, 96, 100};
        reset_dut();
        do_write(3'd5, 8'd16);
        do_write(3'd1, 8'd100);
        do_write(3'd6, 8'h02);
        wait_tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ramp_busy_first: got %b want 1", busy);
        end
        for (int k = 0; k < 7; k++) begin
            run_count(255, 1, h, t);
            n_cmp++;
            if (h != duty[k]) begin
                n_bad++;
                $display("FAIL ramp_duty: step %0d got %0d want %0d", k, h, duty[k]);
            end
            n_cmp++;
            if (busy !== (k < 5)) begin
                n_bad++;
                $display("FAIL ramp_busy: step %0d got %b want %b", k, busy, (k < 5));
            end
        end
    endtask

    task automatic test_extremes();
        int h, t;
        reset_dut();
        do_write(3'd2, 8'd0);
        do_write(3'd3, 8'd255);
        do_write(3'd6, 8'h0C);
        wait_tick();
        run_count(255, 2, h, t);
        n_cmp++;
        if (h != 0) begin
            n_bad++;
            $display("FAIL duty0_low: high=%0d want 0", h);
        end
        run_count(255, 3, h, t);
        n_cmp++;
        if (h != 255) begin
            n_bad++;
            $display("FAIL duty255_high: high=%0d want 255", h);
        end
        do_write(3'd6, 8'h04);
        wait_tick();
        run_count(255, 3, h, t);
        n_cmp++;
        if (h != 0) begin
            n_bad++;
            $display("FAIL mask_clear: high=%0d want 0", h);
        end
    endtask

    task automatic test_prescale();
        int h, t;
        reset_dut();
        do_write(3'd4, 8'd3);
        do_write(3'd0, 8'd10);
        do_write(3'd6, 8'h01);
        wait_tick();
        for (int p = 0; p < 2; p++) begin
            run_count(1020, 0, h, t);
            n_cmp++;
            if (h != 40 || t != 1 || period_tick !== 1'b1) begin
                n_bad++;
                $display("FAIL prescale_period: high=%0d ticks=%0d want 40/1", h, t);
            end
        end
    endtask

    task automatic test_back_to_back();
        int h, t;
        reset_dut();
        do_write(3'd0, 8'd50);
        do_write(3'd6, 8'h01);
        wait_tick();
        for (int k = 0; k < 300 && !m_at_boundary(); k++) cycle();
        wr_valid = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'd120;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_boundary: wr_ready=%b want 0", wr_ready);
        end
        cycle();
        n_cmp++;
        if (wr_ready !== 1'b1 || period_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_next: wr_ready=%b tick=%b want 1/1", wr_ready, period_tick);
        end
        cycle();
        wr_valid = 1'b0;
        do_write(3'd7, 8'hFF);
        wait_tick();
        run_count(255, 0, h, t);
        n_cmp++;
        if (h != 120) begin
            n_bad++;
            $display("FAIL stalled_write_commit: high=%0d want 120", h);
        end
        // Random writes within one period: last write per address wins.
        for (int k = 0; k < 6; k++) do_write(3'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        do_write(3'd0, 8'd77);
        wait_tick();
        run_count(255, 0, h, t);
        n_cmp++;
        if (h != 77) begin
            n_bad++;
            $display("FAIL last_write_wins: high=%0d want 77", h);
        end
    endtask

    task automatic test_ena();
        int n;
        bit seen = 1'b0;
        reset_dut();
        do_write(3'd0, 8'd200);
        do_write(3'd6, 8'h01);
        wait_tick();
        repeat (30) cycle();
        ena = 1'b0;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ena_ready: got %b want 0", wr_ready);
        end
        cycle();
        n_cmp++;
        if (pwm_out !== 4'b0) begin
            n_bad++;
            $display("FAIL ena_pwm_off: got %b want 0000", pwm_out);
        end
        repeat (19) cycle();
        ena = 1'b1;
        n = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            cycle();
            n++;
            if (period_tick === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || n != 225) begin
            n_bad++;
            $display("FAIL ena_hold_cnt: tick after %0d clocks want 225", n);
        end
    endtask

    task automatic test_async_reset();
        int h, t;
        reset_dut();
        do_write(3'd0, 8'd200);
        do_write(3'd6, 8'h01);
        wait_tick();
        repeat (100) cycle();
        do_write(3'd1, 8'd5);
        n_cmp++;
        if (busy !== 1'b1 || pwm_out[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_state: busy=%b pwm0=%b want 1/1", busy, pwm_out[0]);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pwm_out !== 4'b0 || period_tick !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: pwm=%b tick=%b busy=%b want 0/0/0", pwm_out, period_tick, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        run_count(600, 0, h, t);
        n_cmp++;
        if (h != 0 || t != 2) begin
            n_bad++;
            $display("FAIL post_reset_idle: high=%0d ticks=%0d want 0/2", h, t);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_ramp();
        test_extremes();
        test_prescale();
        test_back_to_back();
        test_ena();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
- Four-channel PWM controller and sequencer that sits behind the TinyTapeout top-level wrapper.
- Accepts register writes over a valid/ready handshake into shadow registers.
- Commits the shadow registers to the active PWM state only at period boundaries, so no output period is ever glitched.
- Optional soft ramp moves each channel's active duty toward its target by a fixed step once per period.

Parameters:
- NCH, 4, number of PWM channels; fixed at 4 because the address map below assumes it.
- DW, 8, duty and counter width; period is 2^DW-1 ticks.
- PW, 8, prescaler register width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable from the wrapper
- wr_valid  input  1  write request
- wr_ready  output  1  write can be accepted this cycle
- wr_addr  input  3  register address
- wr_data  input  8  register write data
- pwm_out  output  NCH  PWM outputs, registered
- period_tick  output  1  one-cycle pulse at each period boundary
- busy  output  1  at least one channel is still ramping (active duty != target)

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous and active-low, and takes effect immediately at any time, including mid-period.
  - All registers clear to 0: targets, active duties, prescaler shadow/active, step, mask shadow/active, pre_cnt, cnt, pwm_out, period_tick.
  - busy therefore reads 0 out of reset.
- Address map (shadow registers, written on wr_valid && wr_ready):
  - 0-3: target duty of channel 0-3.
  - 4: prescale (PW bits).
  - 5: ramp step (0 = jump immediately).
  - 6: channel enable mask, low NCH bits.
  - 7: write accepted and discarded.
- Timebase (runs only when ena=1; pre_cnt and cnt hold while ena=0):
  - pre_cnt counts 0..prescale_act; tick = (pre_cnt == prescale_act), and pre_cnt returns to 0 on tick.
  - On tick, cnt counts 0..2^DW-2 (0..254), then wraps to 0. Period = 255*(prescale_act+1) clocks.
  - boundary = ena && tick && (cnt == 254).
- period_tick: registered, equals boundary delayed by one clock.
- Commit on boundary (same clock edge as the cnt wrap):
  - prescale_act <= prescale shadow; mask_act <= mask shadow.
  - Per channel, with step == 0: active <= target.
  - Per channel, with step > 0: active moves toward target by min(step, |target - active|).
  - Difference arithmetic is in DW+1 bits; there is no overflow or overshoot.
- Handshake:
  - wr_ready = ena && !boundary (combinational from registered state).
  - A write held during a boundary cycle stalls one clock, is accepted on the next cycle, and commits at the following boundary.
  - Writes never change active state directly.
  - Multiple writes to the same address within a period: the last one wins.
- PWM output:
  - pwm_out[i] <= ena && mask_act[i] && (cnt < active[i]), registered every clock (one-cycle latency from cnt).
  - Duty 0 gives constant low; duty 255 gives constant high; duty d gives d high ticks out of 255.
- ena=0: pwm_out goes to 0 at the next clock, wr_ready=0, and all state holds. ena=1 resumes from the held counts.
- busy = OR over i of (active[i] != target[i]), combinational from registers.

Test Plan:
- Reset, ena=1, write addr6=0x1, addr0=64, step=0 -> active takes effect from the first boundary after the writes. Each following 255-clock period: pwm_out[0] high for exactly 64 clocks starting one clock after the cnt==0 cycle. period_tick pulses once per 255 clocks.
- step=16, ch1 target 100 from 0, mask=0x2 -> ch1 active is 16,32,48,64,80,96,100 on successive boundaries. busy=1 until the 7th boundary, then 0. No overshoot.
- ch2 target 0 and ch3 target 255, mask=0xC -> pwm_out[2] constantly 0 and pwm_out[3] constantly 1 across full periods. Mask bit cleared -> output 0 from the next boundary.
- prescale=3 -> after the commit boundary, period_tick spacing is 1020 clocks and high time for duty 10 is 40 clocks.
- wr_valid asserted in the boundary cycle -> wr_ready=0 in that cycle, handshake completes next cycle, new value appears one full period later. Addr 7 write changes nothing.
- rst_n pulsed low mid-period with ch0 at duty 200 -> pwm_out, period_tick and busy read 0 immediately (asynchronously). After release, outputs stay 0 until reprogrammed. Separately, ena=0 holds cnt and forces pwm_out to 0 within one clock.
